// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory (async read, sync write).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module dmem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [31:0]   mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;
    logic          r_we_q;
    logic [AW-1:0] r_addr_q;
    logic [DW-1:0] r_wd_q;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_win1;
    logic          w_load;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_mem_we;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_win1 = req1 & ~req0;
`else
    // Tie goes to whichever port did not own the previous access.
    logic r_last_owner;

    assign w_win1 = req1 & (~req0 | ~r_last_owner);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_owner <= 1'b1;
        end else if (r_state == S_ACCESS) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_we    = r_we_q;
                w_gnt0      = ~r_owner;
                w_gnt1      = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wd_q    <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (w_load) begin
                r_owner  <= w_win1;
                r_we_q   <= w_win1 ? we1    : we0;
                r_addr_q <= w_win1 ? addr1  : addr0;
                r_wd_q   <= w_win1 ? wdata1 : wdata0;
            end
            // Read data is captured at the end of the access cycle.
            if (r_state == S_ACCESS && !r_we_q) begin
                if (r_owner) begin
                    r_rdata1  <= mem_rd;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= mem_rd;
                    r_rvalid0 <= 1'b1;
                end
            end
        end
    end

    // Address/data come straight from the latched request, so they hold between accesses.
    assign mem_a   = {{(32-AW){1'b0}}, r_addr_q};
    assign mem_wd  = r_wd_q;
    assign mem_we  = w_mem_we;
    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x32 memory; honours DMEM_ARB_FIXED_PRIO_EN.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:31];
    logic        init;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd [0:1];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[4:0]];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_we) begin
            mem[mem_a[4:0]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " gnt0"}, gnt0, 0);
        chk({tag, " gnt1"}, gnt1, 0);
        chk({tag, " rvalid0"}, rvalid0, 0);
        chk({tag, " rvalid1"}, rvalid1, 0);
        chk({tag, " rdata0"}, rdata0, 0);
        chk({tag, " rdata1"}, rdata1, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_a"}, mem_a, 0);
        chk({tag, " mem_wd"}, mem_wd, 0);
    endtask

    task automatic drive(input logic p, input logic r, input logic we, input logic [4:0] a, input logic [31:0] d);
        if (!p) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
        else    begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    // Single transaction on one port: grant in N+1, rvalid (reads) in N+2.
    task automatic xfer(input logic p, input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
        @(negedge clk);
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        chk($sformatf("%s gnt", tag), p ? gnt1 : gnt0, 1);
        chk($sformatf("%s gnt_other", tag), p ? gnt0 : gnt1, 0);
        chk($sformatf("%s mem_we", tag), mem_we, {31'b0, we});
        chk($sformatf("%s mem_a", tag), mem_a, {27'b0, a});
        if (we) chk($sformatf("%s mem_wd", tag), mem_wd, d);
        drive(p, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk($sformatf("%s rvalid", tag), p ? rvalid1 : rvalid0, {31'b0, ~we});
        if (!we) begin
            chk($sformatf("%s rdata", tag), p ? rdata1 : rdata0, exp);
            last_rd[p] = exp;
        end else begin
            chk($sformatf("%s rdata hold", tag), p ? rdata1 : rdata0, last_rd[p]);
            chk($sformatf("%s mem word", tag), mem[a], d);
        end
    endtask

    // Both ports request in the same cycle; `first` is the port expected to win.
    task automatic pair(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic first, input logic [31:0] e0, input logic [31:0] e1,
                        input string tag);
        logic        p, pw;
        logic [4:0]  pa;
        logic [31:0] pd, pe;
        @(negedge clk);
        drive(1'b0, 1'b1, w0, a0, d0);
        drive(1'b1, 1'b1, w1, a1, d1);
        for (int k = 0; k < 2; k++) begin
            p  = (k == 0) ? first : ~first;
            pw = p ? w1 : w0;
            pa = p ? a1 : a0;
            pd = p ? d1 : d0;
            pe = p ? e1 : e0;
            @(negedge clk);
            chk($sformatf("%s #%0d gnt%0d", tag, k, p), p ? gnt1 : gnt0, 1);
            chk($sformatf("%s #%0d gnt_other", tag, k), p ? gnt0 : gnt1, 0);
            drive(p, 1'b0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            chk($sformatf("%s #%0d rvalid%0d", tag, k, p), p ? rvalid1 : rvalid0, {31'b0, ~pw});
            chk($sformatf("%s #%0d rvalid_other", tag, k), p ? rvalid0 : rvalid1, 0);
            if (!pw) begin
                chk($sformatf("%s #%0d rdata%0d", tag, k, p), p ? rdata1 : rdata0, pe);
                last_rd[p] = pe;
            end else begin
                chk($sformatf("%s #%0d mem word", tag, k), mem[pa], pd);
            end
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [9];

    initial begin
        int n, cyc, seen;
        int cnt [0:1];
        logic exp_owner;

        vt[0] = '{1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'h0};
        vt[1] = '{1'b0, 1'b0, 5'd5,  32'h0,         32'h1234_5678};
        vt[2] = '{1'b1, 1'b0, 5'd5,  32'h0,         32'h1234_5678};
        vt[3] = '{1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h0};
        vt[4] = '{1'b0, 1'b0, 5'd31, 32'h0,         32'hCAFE_F00D};
        vt[5] = '{1'b1, 1'b0, 5'd0,  32'h0,         32'h1000_0000};
        vt[6] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0};
        vt[7] = '{1'b1, 1'b0, 5'd0,  32'h0,         32'hFFFF_FFFF};
        vt[8] = '{1'b0, 1'b0, 5'd9,  32'h0,         32'h1000_0009};

        rst = 1'b0;
        init = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        init = 1'b0;
        rst = 1'b1;

        // Simultaneous reads right after reset: port 0 takes the first tie.
        pair(1'b0, 5'd1, 32'd0, 1'b0, 5'd2, 32'd0, 1'b0, 32'h1000_0001, 32'h1000_0002, "simul");

        // Reset asserted during the access cycle of a write must suppress it.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("midrst gnt0 before", gnt0, 1);
        chk("midrst mem_we before", mem_we, 1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("midrst mem[3]", mem[3], 32'h1000_0003);
        xfer(1'b0, 1'b0, 5'd3, 32'd0, 32'h1000_0003, "post-rst read");

        for (int i = 0; i < 9; i++)
            xfer(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, $sformatf("vec%0d", i));

        // Both ports hold req for 8 grants.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd11, 32'd0);
        n = 0; cyc = 0; cnt[0] = 0; cnt[1] = 0;
        while (n < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("rr overlap", {31'b0, gnt0 & gnt1}, 0);
            if (gnt0 | gnt1) begin
                exp_owner = RR ? n[0] : 1'b0;
                chk($sformatf("rr grant %0d owner", n), {31'b0, gnt1}, {31'b0, exp_owner});
                cnt[gnt1]++;
                n++;
            end
        end
        chk("rr grants seen", n, 8);
        chk("rr count port0", cnt[0], RR ? 4 : 8);
        chk("rr count port1", cnt[1], RR ? 4 : 0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            @(negedge clk);
            if (gnt1) seen = 1;
        end
        chk("gnt1 after req0 drop", seen, 1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Write/read race on addr 7.
        do_reset();
        pair(1'b0, 5'd7, 32'd0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 32'h1000_0007, 32'h0, "race1");
        xfer(1'b0, 1'b0, 5'd7, 32'd0, 32'hA5A5_A5A5, "race mid read");
        pair(1'b0, 5'd7, 32'd0, 1'b1, 5'd7, 32'h5A5A_5A5A, RR ? 1'b1 : 1'b0,
             RR ? 32'h5A5A_5A5A : 32'hA5A5_A5A5, 32'h0, "race2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
